// File: rtl/text_timing_gen.sv
// text_timing_gen
// Raster / character-cell timing generator feeding the text-mode character
// generator. Produces the character RAM read address and the sub-cell
// coordinates in the counter cycle, plus hsync/vsync/video_on delayed so they
// line up with the serialised pixel coming out of the RAM -> ROM -> shift
// pipeline. Reset asserts asynchronously; counting resumes one clock after
// release so the first frame_start pulse is a full, clean cycle at h=0,v=0.

module text_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int COLS     = 80,
  parameter int PIPE_DLY = 10,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        pixel_clock,
  input  logic        reset,
  output logic [13:0] char_address,
  output logic [2:0]  subchar_line,
  output logic [2:0]  subchar_pixel,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Packed {hsync, vsync, video_on} value the delay chain holds when idle.
  localparam logic [2:0] PIPE_IDLE = {~SYNC_POL, ~SYNC_POL, 1'b0};

  logic [10:0] h_cnt_reg;
  logic [10:0] v_cnt_reg;
  logic [6:0]  col_reg;
  logic [13:0] row_base_reg;
  logic        started_reg;

  logic        h_wrap;
  logic        v_wrap;
  logic        raw_active;
  logic        raw_hs;
  logic        raw_vs;
  logic [2:0]  raw_bundle;

  assign h_wrap = (h_cnt_reg == 11'(H_TOTAL - 1));
  assign v_wrap = (v_cnt_reg == 11'(V_TOTAL - 1));

  // Holds the counters at 0,0 for the first clock after reset release.
  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) started_reg <= 1'b0;
    else        started_reg <= 1'b1;
  end

  // Horizontal / vertical raster counters.
  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (started_reg) begin
      if (h_wrap) begin
        h_cnt_reg <= '0;
        if (v_wrap) v_cnt_reg <= '0;
        else        v_cnt_reg <= v_cnt_reg + 11'd1;
      end else begin
        h_cnt_reg <= h_cnt_reg + 11'd1;
      end
    end
  end

  // Column index: advances at the end of each visible 8-pixel cell, holds in blanking.
  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      col_reg <= '0;
    end else if (started_reg) begin
      if (h_wrap)
        col_reg <= '0;
      else if (h_cnt_reg[2:0] == 3'd7 && h_cnt_reg < 11'(H_ACTIVE - 1))
        col_reg <= col_reg + 7'd1;
    end
  end

  // Row base address: adds COLS after the last line of each visible cell row,
  // so the address is formed without a multiplier.
  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      row_base_reg <= '0;
    end else if (started_reg && h_wrap) begin
      if (v_wrap)
        row_base_reg <= '0;
      else if (v_cnt_reg[2:0] == 3'd7 && v_cnt_reg < 11'(V_ACTIVE - 1))
        row_base_reg <= row_base_reg + 14'(COLS);
    end
  end

  assign char_address  = row_base_reg + {7'd0, col_reg};
  assign subchar_pixel = h_cnt_reg[2:0];
  assign subchar_line  = v_cnt_reg[2:0];
  assign frame_start   = started_reg && (h_cnt_reg == 11'd0) && (v_cnt_reg == 11'd0);

  // Undelayed sync/active decode; forced inactive until counting has started.
  always_comb begin
    raw_active = started_reg && (h_cnt_reg < 11'(H_ACTIVE)) && (v_cnt_reg < 11'(V_ACTIVE));
    raw_hs     = ~SYNC_POL;
    raw_vs     = ~SYNC_POL;
    if (started_reg && h_cnt_reg >= 11'(H_ACTIVE + H_FP) &&
        h_cnt_reg < 11'(H_ACTIVE + H_FP + H_SYNC))
      raw_hs = SYNC_POL;
    if (started_reg && v_cnt_reg >= 11'(V_ACTIVE + V_FP) &&
        v_cnt_reg < 11'(V_ACTIVE + V_FP + V_SYNC))
      raw_vs = SYNC_POL;
    raw_bundle = {raw_hs, raw_vs, raw_active};
  end

  generate
    if (PIPE_DLY == 0) begin : g_no_dly
      assign {hsync, vsync, video_on} = raw_bundle;
    end else begin : g_dly
      for (genvar gi = 0; gi < PIPE_DLY; gi++) begin : stage
        logic [2:0] stage_reg;
        logic [2:0] stage_next;
        if (gi == 0) begin : g_first
          assign stage_next = raw_bundle;
        end else begin : g_rest
          assign stage_next = stage[gi-1].stage_reg;
        end
        // One pipeline stage of the sync/active alignment delay.
        always_ff @(posedge pixel_clock or negedge reset) begin
          if (!reset) stage_reg <= PIPE_IDLE;
          else        stage_reg <= stage_next;
        end
      end
      assign {hsync, vsync, video_on} = stage[PIPE_DLY-1].stage_reg;
    end
  endgenerate

endmodule

// File: tb/tb_text_timing_gen.sv
// Testbench for text_timing_gen. Uses a reduced raster so several frames and
// randomly placed mid-frame resets fit in a short run. The reference model
// tracks a linear pixel position within the frame and derives every output
// arithmetically from it; sync/active delay is a queue of past raw values.

module tb_text_timing_gen;

  localparam int HA   = 40;
  localparam int HFP  = 4;
  localparam int HS   = 6;
  localparam int HBP  = 6;
  localparam int VA   = 24;
  localparam int VFP  = 2;
  localparam int VS   = 2;
  localparam int VBP  = 3;
  localparam int COLS = HA / 8;
  localparam int DLY  = 10;
  localparam int HT   = HA + HFP + HS + HBP;
  localparam int VT   = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;

  logic        pixel_clock;
  logic        reset;
  logic [13:0] char_address;
  logic [2:0]  subchar_line;
  logic [2:0]  subchar_pixel;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic        frame_start;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: pos = -1 while held in reset / before counting starts.
  int         pos;
  logic [2:0] hist[$];

  text_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .COLS(COLS), .PIPE_DLY(DLY), .SYNC_POL(1'b0)
  ) dut (
    .pixel_clock  (pixel_clock),
    .reset        (reset),
    .char_address (char_address),
    .subchar_line (subchar_line),
    .subchar_pixel(subchar_pixel),
    .hsync        (hsync),
    .vsync        (vsync),
    .video_on     (video_on),
    .frame_start  (frame_start)
  );

  initial pixel_clock = 1'b0;
  always #5 pixel_clock = ~pixel_clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at pos %0d: got %0d expected %0d (t=%0t)", tag, pos, got, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Raw {hsync, vsync, active} for a frame position (sync active-low).
  function automatic logic [2:0] model_raw(input int p);
    int h, v;
    logic hs, vs, act;
    if (p < 0) return 3'b110;
    h   = p % HT;
    v   = p / HT;
    hs  = !(h >= HA + HFP && h < HA + HFP + HS);
    vs  = !(v >= VA + VFP && v < VA + VFP + VS);
    act = (h < HA) && (v < VA);
    return {hs, vs, act};
  endfunction

  task automatic model_reset();
    pos = -1;
    hist.delete();
    for (int i = 0; i < DLY; i++) hist.push_back(3'b110);
  endtask

  task automatic model_edge();
    hist.push_back(model_raw(pos));
    void'(hist.pop_front());
    pos = (pos < 0) ? 0 : (pos + 1) % FRAME;
  endtask

  task automatic check_all();
    int p, h, v, exp_addr;
    p = (pos < 0) ? 0 : pos;
    h = p % HT;
    v = p / HT;
    exp_addr = (imin(v, VA - 1) / 8) * COLS + imin(h, HA - 1) / 8;
    check_val("char_address",  32'(char_address),  32'(exp_addr));
    check_val("subchar_pixel", 32'(subchar_pixel), 32'(h % 8));
    check_val("subchar_line",  32'(subchar_line),  32'(v % 8));
    check_val("frame_start",   32'(frame_start),   32'(pos == 0));
    check_val("hsync",         32'(hsync),         32'(hist[0][2]));
    check_val("vsync",         32'(vsync),         32'(hist[0][1]));
    check_val("video_on",      32'(video_on),      32'(hist[0][0]));
  endtask

  // One clock: advance the model on the rising edge, compare on the falling edge.
  task automatic step();
    @(posedge pixel_clock);
    if (reset) model_edge();
    @(negedge pixel_clock);
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous assertion partway through the low clock phase, hold, then release.
  task automatic pulse_reset(input int hold);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
    run(hold);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    model_reset();
    $display("[TB] power-on reset held 5 clocks");
    run(5);
    reset = 1'b1;
    $display("[TB] released; running two frames");
    run(1);
    check_val("first_frame_start", 32'(frame_start), 32'd1);
    run(2 * FRAME + 100);
    for (int r = 0; r < 6; r++) begin
      int len, hold;
      len  = $urandom_range(20, 1800);
      hold = $urandom_range(1, 4);
      run(len);
      $display("[TB] reset pulse %0d at pos %0d, hold %0d clocks", r, pos, hold);
      pulse_reset(hold);
      run(1);
      check_val("restart_frame_start", 32'(frame_start), 32'd1);
    end
    run(FRAME + 50);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
